// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined carry-select adder family.
package adder_pkg;

    // Operation select values on the sub input.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Number of carry-select blocks for a given operand width and block size.
    function automatic int nblk(input int width, input int block);
        return width / block;
    endfunction

endpackage

// File: rtl/pipelined_csel_adder_csel_block.sv
// Combinational BLOCK-bit dual adder: produces the sum and carry for both
// possible carry-ins so the select chain only has to pick one later.
module csel_block #(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] a_i,
    input  logic [BLOCK-1:0] b_i,
    output logic [BLOCK-1:0] sum0_o,
    output logic             c0_o,
    output logic [BLOCK-1:0] sum1_o,
    output logic             c1_o
);

    assign {c0_o, sum0_o} = {1'b0, a_i} + {1'b0, b_i};
    assign {c1_o, sum1_o} = {1'b0, a_i} + {1'b0, b_i} + {{BLOCK{1'b0}}, 1'b1};

endmodule

// File: rtl/pipelined_csel_adder.sv
// Two-stage carry-select adder/subtractor with valid/ready handshake.
// Stage 1 registers block 0's true sum plus both carry candidates of every
// higher block; stage 2 resolves the select chain and registers the flags.
module pipelined_csel_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int NBLK = nblk(WIDTH, BLOCK);

    if (BLOCK < 1 || BLOCK > WIDTH || (WIDTH % BLOCK) != 0) begin : g_bad_params
        $error("pipelined_csel_adder: WIDTH must be a non-zero multiple of BLOCK");
    end

    // Candidate pair for one block; kept here because a package cannot take
    // the BLOCK parameter.
    typedef struct packed {
        logic [BLOCK-1:0] sum0;
        logic             c0;
        logic [BLOCK-1:0] sum1;
        logic             c1;
    } cand_t;

    logic             en;
    logic             accept;
    logic [WIDTH-1:0] be;
    logic             ce;

    logic             v1_q;
    logic [BLOCK-1:0] blk0_sum_d, blk0_sum_q;
    logic             blk0_c_d, blk0_c_q;
    logic             a_msb_q, be_msb_q;

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;
    logic             zero_d, zero_q;
    logic             out_valid_q;

    // Whole pipe moves together; a stalled output freezes both stages.
    assign en       = ~out_valid_q | out_ready;
    assign in_ready = en;
    assign accept   = in_valid & en;

    assign be = (sub == OP_SUB) ? ~b : b;
    assign ce = cin ^ sub;

    assign {blk0_c_d, blk0_sum_d} = {1'b0, a[BLOCK-1:0]} + {1'b0, be[BLOCK-1:0]}
                                    + {{BLOCK{1'b0}}, ce};

    // Stage 1: valid bit follows every advance (bubbles included); data only on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q       <= 1'b0;
            blk0_sum_q <= '0;
            blk0_c_q   <= 1'b0;
            a_msb_q    <= 1'b0;
            be_msb_q   <= 1'b0;
        end else if (en) begin
            v1_q <= in_valid;
            if (in_valid) begin
                blk0_sum_q <= blk0_sum_d;
                blk0_c_q   <= blk0_c_d;
                a_msb_q    <= a[WIDTH-1];
                be_msb_q   <= be[WIDTH-1];
            end
        end
    end

    if (NBLK > 1) begin : g_hi
        cand_t                  cand_d [NBLK-1];
        cand_t                  cand_q [NBLK-1];
        logic [WIDTH-BLOCK-1:0] hi_sum;
        logic                   carry;

        for (genvar k = 1; k < NBLK; k++) begin : g_blk
            csel_block #(.BLOCK(BLOCK)) u_csel (
                .a_i    (a[k*BLOCK +: BLOCK]),
                .b_i    (be[k*BLOCK +: BLOCK]),
                .sum0_o (cand_d[k-1].sum0),
                .c0_o   (cand_d[k-1].c0),
                .sum1_o (cand_d[k-1].sum1),
                .c1_o   (cand_d[k-1].c1)
            );
        end

        // Stage 1 candidate registers for blocks 1..NBLK-1.
        always_ff @(posedge clk) begin
            if (rst) begin
                cand_q <= '{default: '0};
            end else if (accept) begin
                cand_q <= cand_d;
            end
        end

        // Select chain: each block's resolved carry picks the next block's pair.
        always_comb begin
            hi_sum = '0;
            carry  = blk0_c_q;
            for (int k = 1; k < NBLK; k++) begin
                hi_sum[(k-1)*BLOCK +: BLOCK] = carry ? cand_q[k-1].sum1 : cand_q[k-1].sum0;
                carry = carry ? cand_q[k-1].c1 : cand_q[k-1].c0;
            end
        end

        assign sum_d  = {hi_sum, blk0_sum_q};
        assign cout_d = carry;
    end else begin : g_one
        assign sum_d  = blk0_sum_q;
        assign cout_d = blk0_c_q;
    end

    assign ovf_d  = (a_msb_q == be_msb_q) && (sum_d[WIDTH-1] != a_msb_q);
    assign zero_d = ~|sum_d;

    // Stage 2: register the resolved result and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (en) begin
            out_valid_q <= v1_q;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Scoreboard bench: stimulus pushes expected results, monitors pop on transfer.
module tb_pipelined_csel_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, sum;
    logic        cin, sub, cout, overflow, zero;

    logic        v16, r16, ov16, or16, c16, o16, z16, cin16, sub16;
    logic [15:0] a16, b16, s16;
    logic        v8, r8, ov8, or8, c8, o8, z8, cin8, sub8;
    logic [7:0]  a8, b8, s8;

    pipelined_csel_adder #(.WIDTH(32), .BLOCK(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
    );

    pipelined_csel_adder #(.WIDTH(16), .BLOCK(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16), .out_valid(ov16),
        .out_ready(or16), .sum(s16), .cout(c16), .overflow(o16), .zero(z16)
    );

    pipelined_csel_adder #(.WIDTH(8), .BLOCK(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(ov8),
        .out_ready(or8), .sum(s8), .cout(c8), .overflow(o8), .zero(z8)
    );

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          due;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];
    exp_t q8[$];
    exp_t e32, e16, e8;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit bp_arm  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send32(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                          input logic sb, input logic [31:0] es, input logic ec,
                          input logic eo, input logic ez, input bit lat);
        int n = 0;
        a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL send32_timeout: in_ready stuck at %b", in_ready);
            in_valid = 1'b0;
            return;
        end
        q32.push_back('{sum: es, cout: ec, ovf: eo, zero: ez, due: lat ? cyc + 2 : -1});
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q16.size() != 0 || q8.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (q32.size() != 0 || q16.size() != 0 || q8.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending %0d/%0d/%0d expected 0/0/0",
                     q32.size(), q16.size(), q8.size());
            q32.delete(); q16.delete(); q8.delete();
        end
    endtask

    // Monitor for the 32-bit instance: compare on every output transfer.
    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q32.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out32: got sum 0x%0h expected no beat", sum);
            end else begin
                e32 = q32.pop_front();
                chk("sum32", sum, e32.sum);
                chk("cout32", {31'b0, cout}, {31'b0, e32.cout});
                chk("ovf32", {31'b0, overflow}, {31'b0, e32.ovf});
                chk("zero32", {31'b0, zero}, {31'b0, e32.zero});
                if (e32.due >= 0) chk("latency32", cyc, e32.due);
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && ov16 === 1'b1) begin
            if (q16.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out16: got sum 0x%0h expected no beat", s16);
            end else begin
                e16 = q16.pop_front();
                chk("sum16", {16'b0, s16}, e16.sum);
                chk("cout16", {31'b0, c16}, {31'b0, e16.cout});
                chk("ovf16", {31'b0, o16}, {31'b0, e16.ovf});
                chk("zero16", {31'b0, z16}, {31'b0, e16.zero});
                chk("latency16", cyc, e16.due);
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && ov8 === 1'b1) begin
            if (q8.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out8: got sum 0x%0h expected no beat", s8);
            end else begin
                e8 = q8.pop_front();
                chk("sum8", {24'b0, s8}, e8.sum);
                chk("cout8", {31'b0, c8}, {31'b0, e8.cout});
                chk("ovf8", {31'b0, o8}, {31'b0, e8.ovf});
                chk("zero8", {31'b0, z8}, {31'b0, e8.zero});
                chk("latency8", cyc, e8.due);
            end
        end
    end

    // Backpressure driver: hold the first result of the armed burst for 3 edges.
    initial begin
        int n;
        out_ready = 1'b1;
        wait (bp_arm == 1'b1);
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (out_valid !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL bp_wait: out_valid %b expected 1", out_valid);
        end else begin
            out_ready = 1'b0;
            repeat (3) begin
                @(negedge clk);
                chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
                chk("bp_out_valid", {31'b0, out_valid}, 32'h1);
                chk("bp_sum_held", sum, 32'h2);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b1; a = 32'h5; b = 32'h5; cin = 1'b0; sub = 1'b0;
        v16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; or16 = 1'b1;
        v8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0; sub8  = 1'b0; or8  = 1'b1;

        // Two reset edges while the input keeps streaming.
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_sum", sum, 32'h0);
        chk("rst_cout", {31'b0, cout}, 32'h0);
        chk("rst_ovf", {31'b0, overflow}, 32'h0);
        chk("rst_zero", {31'b0, zero}, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
        rst = 1'b0;

        // Back-to-back directed vectors, each expected 2 cycles after accept.
        send32(32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0, 32'h0000_000A, 1'b0, 1'b0, 1'b0, 1'b1);
        send32(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b1);
        send32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
        send32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
        send32(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b1);
        send32(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b1);
        send32(32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        send32(32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0, 1'b0, 1'b1);
        send32(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0, 1'b0, 1'b0, 1'b1);
        send32(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b1);
        in_valid = 1'b0;
        drain();

        // A beat in flight when reset arrives must be discarded.
        a = 32'h1; b = 32'h1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {31'b0, out_valid}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_discard", {31'b0, out_valid}, 32'h0);
        @(negedge clk);

        // Backpressure burst: results must arrive in order, none lost.
        bp_arm = 1'b1;
        send32(32'h1, 32'h1, 1'b0, 1'b0, 32'h2, 1'b0, 1'b0, 1'b0, 1'b0);
        send32(32'h2, 32'h2, 1'b0, 1'b0, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0);
        send32(32'h3, 32'h3, 1'b0, 1'b0, 32'h6, 1'b0, 1'b0, 1'b0, 1'b0);
        send32(32'h4, 32'h4, 1'b0, 1'b0, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
        drain();

        // Re-parametrised instances: 16/4 and the single-block 8/8 case.
        chk("ready16", {31'b0, r16}, 32'h1);
        chk("ready8", {31'b0, r8}, 32'h1);
        a16 = 16'h1234; b16 = 16'h0FCC; v16 = 1'b1;
        a8  = 8'hFF;    b8  = 8'h01;    v8  = 1'b1;
        q16.push_back('{sum: 32'h2200, cout: 1'b0, ovf: 1'b0, zero: 1'b0, due: cyc + 2});
        q8.push_back('{sum: 32'h00, cout: 1'b1, ovf: 1'b0, zero: 1'b1, due: cyc + 2});
        @(negedge clk);
        a16 = 16'h8000; b16 = 16'h8000;
        a8  = 8'h7F;    b8  = 8'h01;
        q16.push_back('{sum: 32'h0000, cout: 1'b1, ovf: 1'b1, zero: 1'b1, due: cyc + 2});
        q8.push_back('{sum: 32'h80, cout: 1'b0, ovf: 1'b1, zero: 1'b0, due: cyc + 2});
        @(negedge clk);
        a8 = 8'h05; b8 = 8'h07; sub8 = 1'b1;
        q8.push_back('{sum: 32'hFE, cout: 1'b0, ovf: 1'b0, zero: 1'b0, due: cyc + 2});
        v16 = 1'b0;
        @(negedge clk);
        v8 = 1'b0;
        drain();

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
